// File: rtl/gost34_12_2015_sbox_sched.sv
// Magma (GOST 34.12-2015) substitution-layer sequencer.
// Holds eight 16x4 S-box tables written over a config port. Each SUB cycle it
// substitutes LANES nibbles of the captured word. It then rotates the result
// left by ROT and presents it with a valid/ready handshake.
module gost34_12_2015_sbox_sched #(
  parameter int LANES = 1,   // nibble lookups per SUB cycle: 1, 2, 4 or 8
  parameter int ROT   = 11   // rotate-left amount, 0..31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [63:0] cfg_data,
  output logic        cfg_err,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last counter value before leaving SUB, and the per-cycle counter step.
  // With LANES=8 the step truncates to 0, which is harmless because the
  // first SUB cycle is also the last one.
  localparam logic [2:0] CNT_LAST = 3'(8 - LANES);
  localparam logic [2:0] CNT_STEP = 3'(LANES);

  state_t      state;
  state_t      state_next;
  logic [63:0] tables [8];
  logic [31:0] work;
  logic [31:0] sub_word;
  logic [31:0] rotated;
  logic [63:0] rot_wide;
  logic [2:0]  cnt;
  logic        sub_last;
  logic [2:0]  lane_idx [LANES];
  logic [3:0]  lane_val [LANES];

  // Table entry 0 sits in the top nibble. Entry x therefore starts at bit
  // 4*(15-x), and 15-x is simply ~x.
  function automatic logic [3:0] sbox_lookup(input logic [63:0] tab, input logic [3:0] x);
    return tab[{~x, 2'b00} +: 4];
  endfunction

  // One lookup lane per nibble handled this cycle. Lane gi works on nibble cnt+gi.
  // cnt+gi never exceeds 7, because cnt stays a multiple of LANES.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_idx[gi] = cnt + 3'(gi);
    assign lane_val[gi] = sbox_lookup(tables[lane_idx[gi]], work[{lane_idx[gi], 2'b00} +: 4]);
  end

  // Work word with this cycle's nibbles replaced by their substitutions.
  always_comb begin
    sub_word = work;
    for (int i = 0; i < LANES; i++) begin
      sub_word[{lane_idx[i], 2'b00} +: 4] = lane_val[i];
    end
  end

  // Rotate-left by ROT, taken from the low half of a doubled word. ROT=0 shifts by 32.
  assign rot_wide = {sub_word, sub_word} >> (32 - ROT);
  assign rotated  = rot_wide[31:0];
  assign sub_last = (cnt == CNT_LAST);

  // Next-state logic for the IDLE -> SUB -> DONE -> IDLE sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = SUB;
      SUB:     if (sub_last)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Work register, nibble counter and output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work     <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_data;
            cnt  <= '0;
          end
        end
        SUB: begin
          work <= sub_word;
          if (sub_last) begin
            cnt      <= '0;
            out_data <= rotated;
          end else begin
            cnt <= cnt + CNT_STEP;
          end
        end
        default: ;
      endcase
    end
  end

  // S-box tables. Writes land only while idle, so a word in flight never sees a
  // half-updated table set. A write attempted while busy is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) tables[i] <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && (state != IDLE);
      if (cfg_we && (state == IDLE)) tables[cfg_addr] <= cfg_data;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
